// File: rtl/fft_in_pack8_pkg.sv
// Shared constants and the 3-bit bit-reversal helper for the 8-point FFT datapath.
package fft_in_pack8_pkg;

    localparam int FFT_DATA_WID = 16;
    localparam int FFT_PTS8     = 8;

    function automatic logic [2:0] bitrev3(input logic [2:0] idx);
        return {idx[0], idx[1], idx[2]};
    endfunction

endpackage

// File: rtl/fft_in_pack8_bank.sv
// One 8-lane complex register bank; a single lane is written per cycle when enabled.
module fft_in_pack8_bank
    import fft_in_pack8_pkg::*;
#(
    parameter int DATA_WID = FFT_DATA_WID
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           we_i,
    input  logic [2:0]                     lane_i,
    input  logic [DATA_WID-1:0]            re_i,
    input  logic [DATA_WID-1:0]            im_i,
    output logic [FFT_PTS8*DATA_WID-1:0]   re_o,
    output logic [FFT_PTS8*DATA_WID-1:0]   im_o
);

    logic [FFT_PTS8*DATA_WID-1:0] re_q;
    logic [FFT_PTS8*DATA_WID-1:0] im_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            re_q <= '0;
            im_q <= '0;
        end else if (we_i) begin
            re_q[lane_i*DATA_WID +: DATA_WID] <= re_i;
            im_q[lane_i*DATA_WID +: DATA_WID] <= im_i;
        end
    end

    assign re_o = re_q;
    assign im_o = im_q;

endmodule

// File: rtl/fft_in_pack8.sv
// Ping-pong input packer: gathers 8 complex samples per bank (optionally bit-reversed)
// and presents a completed bank to the combinational 8-point FFT core.
module fft_in_pack8
    import fft_in_pack8_pkg::*;
#(
    parameter int DATA_WID = FFT_DATA_WID,
    parameter bit BITREV   = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush_i,
    input  logic                         in_vld_i,
    output logic                         in_rdy_o,
    input  logic [DATA_WID-1:0]          in_re_i,
    input  logic [DATA_WID-1:0]          in_im_i,
    output logic                         out_vld_o,
    input  logic                         out_rdy_i,
    output logic [FFT_PTS8*DATA_WID-1:0] out_re_o,
    output logic [FFT_PTS8*DATA_WID-1:0] out_im_o,
    output logic [1:0]                   level_o
);

    logic       wr_bank_q, wr_bank_d;
    logic       rd_bank_q, rd_bank_d;
    logic [2:0] widx_q, widx_d;
    logic [1:0] full_q, full_d;
    logic       accept, drain;
    logic [2:0] lane;

    logic [FFT_PTS8*DATA_WID-1:0] b0_re, b0_im, b1_re, b1_im;

    // Ready depends only on registered state, so out_rdy_i never reaches in_rdy_o.
    assign in_rdy_o  = !full_q[wr_bank_q];
    assign out_vld_o = full_q[rd_bank_q];
    assign accept    = in_vld_i && in_rdy_o && !flush_i;
    assign drain     = out_vld_o && out_rdy_i && !flush_i;
    assign lane      = BITREV ? bitrev3(widx_q) : widx_q;

    always_comb begin
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        widx_d    = widx_q;
        full_d    = full_q;
        if (flush_i) begin
            wr_bank_d = 1'b0;
            rd_bank_d = 1'b0;
            widx_d    = 3'd0;
            full_d    = 2'b00;
        end else begin
            if (accept) begin
                widx_d = widx_q + 3'd1;
                if (widx_q == 3'd7) begin
                    full_d[wr_bank_q] = 1'b1;
                    wr_bank_d         = !wr_bank_q;
                end
            end
            // Fill and drain always target different banks, so both may apply.
            if (drain) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = !rd_bank_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            widx_q    <= 3'd0;
            full_q    <= 2'b00;
        end else begin
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            widx_q    <= widx_d;
            full_q    <= full_d;
        end
    end

    fft_in_pack8_bank #(.DATA_WID(DATA_WID)) u_bank0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .we_i   (accept && !wr_bank_q),
        .lane_i (lane),
        .re_i   (in_re_i),
        .im_i   (in_im_i),
        .re_o   (b0_re),
        .im_o   (b0_im)
    );

    fft_in_pack8_bank #(.DATA_WID(DATA_WID)) u_bank1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .we_i   (accept && wr_bank_q),
        .lane_i (lane),
        .re_i   (in_re_i),
        .im_i   (in_im_i),
        .re_o   (b1_re),
        .im_o   (b1_im)
    );

    assign out_re_o = rd_bank_q ? b1_re : b0_re;
    assign out_im_o = rd_bank_q ? b1_im : b0_im;
    assign level_o  = {1'b0, full_q[0]} + {1'b0, full_q[1]};

endmodule

// File: tb/tb_fft_in_pack8.sv
// Directed self-checking bench for fft_in_pack8 (bit-reversed instance plus a natural-order instance).
module tb_fft_in_pack8;

    localparam int W = 16;

    logic            clk;
    logic            rst_n;
    logic            flush_i;
    logic            in_vld_i;
    logic            out_rdy_i;
    logic [W-1:0]    in_re_i;
    logic [W-1:0]    in_im_i;
    logic            in_rdy_o, out_vld_o;
    logic [8*W-1:0]  out_re_o, out_im_o;
    logic [1:0]      level_o;
    logic            n_in_rdy_o, n_out_vld_o;
    logic [8*W-1:0]  n_out_re_o, n_out_im_o;
    logic [1:0]      n_level_o;

    int n_chk  = 0;
    int n_fail = 0;
    int drains = 0;

    fft_in_pack8 #(.DATA_WID(W), .BITREV(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .in_vld_i(in_vld_i), .in_rdy_o(in_rdy_o),
        .in_re_i(in_re_i), .in_im_i(in_im_i),
        .out_vld_o(out_vld_o), .out_rdy_i(out_rdy_i),
        .out_re_o(out_re_o), .out_im_o(out_im_o), .level_o(level_o)
    );

    fft_in_pack8 #(.DATA_WID(W), .BITREV(1'b0)) dut_nat (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .in_vld_i(in_vld_i), .in_rdy_o(n_in_rdy_o),
        .in_re_i(in_re_i), .in_im_i(in_im_i),
        .out_vld_o(n_out_vld_o), .out_rdy_i(out_rdy_i),
        .out_re_o(n_out_re_o), .out_im_o(n_out_im_o), .level_o(n_level_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (out_vld_o && out_rdy_i) drains <= drains + 1;

    function automatic logic [8*W-1:0] pk(input int a0, a1, a2, a3, a4, a5, a6, a7);
        int a[8];
        logic [8*W-1:0] r;
        a[0] = a0; a[1] = a1; a[2] = a2; a[3] = a3;
        a[4] = a4; a[5] = a5; a[6] = a6; a[7] = a7;
        r = '0;
        for (int k = 0; k < 8; k++) r[k*W +: W] = W'(a[k]);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [8*W-1:0] obs, input logic [8*W-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one sample and hold it until accepted (bounded).
    task automatic send(input int v);
        logic rdy;
        in_vld_i = 1'b1;
        in_re_i  = W'(v);
        in_im_i  = W'(-v);
        for (int n = 0; n < 50; n++) begin
            rdy = in_rdy_o;
            tick();
            if (rdy) return;
        end
        chk("send_timeout", 1'b1, 1'b0);
    endtask

    initial begin
        logic lowseen;
        int   maxlvl;
        int   d0;

        rst_n = 1'b0; flush_i = 1'b0; in_vld_i = 1'b0; out_rdy_i = 1'b0;
        in_re_i = '0; in_im_i = '0;
        #1;
        chk("rst_in_rdy",  in_rdy_o,  1'b1);
        chk("rst_out_vld", out_vld_o, 1'b0);
        chk("rst_out_re",  out_re_o,  '0);
        chk("rst_out_im",  out_im_o,  '0);
        chk("rst_level",   level_o,   2'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // Ramp: bit-reversed and natural instances
        out_rdy_i = 1'b1;
        for (int i = 1; i <= 8; i++) send(i);
        in_vld_i = 1'b0;
        chk("ramp_vld",    out_vld_o,  1'b1);
        chk("ramp_re",     out_re_o,   pk(1, 5, 3, 7, 2, 6, 4, 8));
        chk("ramp_im",     out_im_o,   pk(-1, -5, -3, -7, -2, -6, -4, -8));
        chk("ramp_level",  level_o,    2'd1);
        chk("nat_vld",     n_out_vld_o, 1'b1);
        chk("nat_re",      n_out_re_o, pk(1, 2, 3, 4, 5, 6, 7, 8));
        chk("nat_im",      n_out_im_o, pk(-1, -2, -3, -4, -5, -6, -7, -8));
        tick();
        chk("ramp_vld_pulse", out_vld_o, 1'b0);
        chk("ramp_level_0",   level_o,   2'd0);

        // Backpressure: 16 samples fill both banks
        out_rdy_i = 1'b0;
        for (int i = 0; i < 16; i++) send(10 + i);
        in_vld_i = 1'b1; in_re_i = W'(26); in_im_i = W'(-26);
        chk("bp_in_rdy_low", in_rdy_o, 1'b0);
        chk("bp_level2",     level_o,  2'd2);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("bp_hold_rdy", in_rdy_o,  1'b0);
            chk("bp_hold_vld", out_vld_o, 1'b1);
            chk("bp_hold_re",  out_re_o,  pk(10, 14, 12, 16, 11, 15, 13, 17));
            chk("bp_hold_im",  out_im_o,  pk(-10, -14, -12, -16, -11, -15, -13, -17));
        end
        out_rdy_i = 1'b1;
        tick();
        out_rdy_i = 1'b0;
        chk("bp_rdy_back",  in_rdy_o, 1'b1);
        chk("bp_level1",    level_o,  2'd1);
        chk("bp_vecB_re",   out_re_o, pk(18, 22, 20, 24, 19, 23, 21, 25));
        for (int i = 16; i < 24; i++) send(10 + i);
        in_vld_i = 1'b0;
        chk("bp_level2b", level_o, 2'd2);
        out_rdy_i = 1'b1;
        tick();
        out_rdy_i = 1'b0;
        chk("bp_vecC_lane0", out_re_o[W-1:0], W'(26));
        chk("bp_vecC_re",    out_re_o, pk(26, 30, 28, 32, 27, 31, 29, 33));
        chk("bp_vecC_im",    out_im_o, pk(-26, -30, -28, -32, -27, -31, -29, -33));
        out_rdy_i = 1'b1;
        tick();
        chk("bp_empty", level_o, 2'd0);

        // Continuous stream of 64 samples
        lowseen = 1'b0; maxlvl = 0; d0 = drains;
        for (int i = 0; i < 64; i++) begin
            in_vld_i = 1'b1; in_re_i = W'(200 + i); in_im_i = W'(-(200 + i));
            if (!in_rdy_o) lowseen = 1'b1;
            if (int'(level_o) > maxlvl) maxlvl = int'(level_o);
            tick();
        end
        in_vld_i = 1'b0;
        if (int'(level_o) > maxlvl) maxlvl = int'(level_o);
        tick();
        chk("cs_no_stall",  lowseen, 1'b0);
        chk("cs_max_level", maxlvl <= 1, 1'b1);
        chk("cs_vectors",   drains - d0, 8);
        chk("cs_level0",    level_o, 2'd0);

        // Flush mid-group, with a competing valid sample on the flush cycle
        out_rdy_i = 1'b0;
        for (int i = 0; i < 5; i++) send(50 + i);
        flush_i = 1'b1; in_vld_i = 1'b1; in_re_i = W'(99); in_im_i = W'(-99);
        tick();
        flush_i = 1'b0; in_vld_i = 1'b0;
        chk("fl_level", level_o,  2'd0);
        chk("fl_rdy",   in_rdy_o, 1'b1);
        for (int i = 0; i < 8; i++) send(100 + i);
        in_vld_i = 1'b0;
        chk("fl_vld", out_vld_o, 1'b1);
        chk("fl_re",  out_re_o, pk(100, 104, 102, 106, 101, 105, 103, 107));
        chk("fl_im",  out_im_o, pk(-100, -104, -102, -106, -101, -105, -103, -107));
        out_rdy_i = 1'b1;
        tick();
        chk("fl_drained", level_o, 2'd0);

        // Reset with one full bank plus three samples
        out_rdy_i = 1'b0;
        for (int i = 0; i < 8; i++) send(60 + i);
        for (int i = 0; i < 3; i++) send(70 + i);
        in_vld_i = 1'b0;
        chk("rm_pre_level", level_o, 2'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rm_vld",   out_vld_o, 1'b0);
        chk("rm_re",    out_re_o,  '0);
        chk("rm_im",    out_im_o,  '0);
        chk("rm_rdy",   in_rdy_o,  1'b1);
        chk("rm_level", level_o,   2'd0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) send(80 + i);
        in_vld_i = 1'b0;
        chk("rm_post_vld", out_vld_o, 1'b1);
        chk("rm_post_re",  out_re_o,  pk(80, 84, 82, 86, 81, 85, 83, 87));
        chk("rm_post_nat", n_out_re_o, pk(80, 81, 82, 83, 84, 85, 86, 87));
        chk("rm_post_lvl", level_o,   2'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_in_pack8.md
# fft_in_pack8

Input packer for the 8-point FFT core. It accepts one complex sample per cycle over a valid/ready handshake and gathers each group of eight samples in a double-buffered (ping-pong) register bank. The samples are stored in 3-bit bit-reversed order, and each completed group is presented to the downstream combinational 8-point core as packed `8*DATA_WID` real and imaginary buses. Two banks let the upstream keep streaming while the downstream holds a completed vector.

## Interface
Parameters:
- `DATA_WID`, default `` `DATA_WID `` (from `fft_defines.vh`): sample width, signed two's complement.
- `BITREV`, default 1: 1 = bit-reversed lane placement; 0 = natural order.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `flush_i`  in  1  synchronous clear of counters and full flags; bank data is kept.
- `in_vld_i`  in  1  input sample valid.
- `in_rdy_o`  out  1  packer can accept a sample.
- `in_re_i`  in  DATA_WID  sample real part.
- `in_im_i`  in  DATA_WID  sample imaginary part.
- `out_vld_o`  out  1  packed vector valid.
- `out_rdy_i`  in  1  downstream takes the vector.
- `out_re_o`  out  8*DATA_WID  packed real parts; lane k occupies bits [(k+1)*DATA_WID-1 : k*DATA_WID].
- `out_im_o`  out  8*DATA_WID  packed imaginary parts, same lane layout.
- `level_o`  out  2  number of full banks (0..2).

## Operation
- **State.** The block holds:
  - two banks of 8 complex registers;
  - `wr_bank` and `rd_bank` (1 bit each);
  - a write index `widx` (3 bits);
  - `full[1:0]` flags.
- **Accept.** `in_rdy_o = !full[wr_bank]`. A sample is accepted when `in_vld_i && in_rdy_o`. It is written to lane `bitrev3(widx)` (or lane `widx` when `BITREV=0`) of bank `wr_bank`, and `widx` increments.
- **Bit-reversed mapping** (sample index → lane): x0→0, x4→1, x2→2, x6→3, x1→4, x5→5, x3→6, x7→7.
- **Fill.** When `widx==7` is accepted:
  - `full[wr_bank]` is set;
  - `wr_bank` toggles;
  - `widx` wraps to 0.
- **Output.**
  - `out_vld_o = full[rd_bank]`.
  - `out_re_o` / `out_im_o` are bank `rd_bank` driven directly from the registers. There is no extra register stage.
  - They stay stable while `out_vld_o && !out_rdy_i`.
- **Drain.** On `out_vld_o && out_rdy_i`, `full[rd_bank]` clears and `rd_bank` toggles.
- **Simultaneous events.**
  - A fill of one bank and a drain of the other in the same cycle both take effect, so `level_o` is unchanged.
  - The same bank can never fill and drain in one cycle.
- **Full.** With both banks full, `in_rdy_o=0`. Upstream must hold its sample and that sample is not lost. `in_rdy_o` returns to 1 in the cycle after the drain.
- **Flush.**
  - `flush_i` clears `widx`, `wr_bank`, `rd_bank` and `full`.
  - It has priority over a same-cycle accept or drain.
  - A partial group is discarded.
- **Reset values.** During and after reset, all bank registers are 0, `widx=0`, both banks are 0, and `full=0`. This gives:
  - `in_rdy_o=1`;
  - `out_vld_o=0`;
  - `out_re_o=0` and `out_im_o=0`;
  - `level_o=0`.
- **Reset mid-operation.** Assertion clears everything immediately (asynchronously). No partial vector is ever presented.
- **Widths.** No arithmetic is performed on sample data. Values pass bit-exact; there is no sign extension and no rounding.

## Timing
- **Latency.** If the 8th sample of a group is accepted at edge t, `out_vld_o` is high after edge t and the vector is sampled at edge t+1 if `out_rdy_i=1`.
- **Throughput.** One sample per cycle is sustained indefinitely while `out_rdy_i` is asserted at least once every 8 cycles.
- **Buffering.** Up to 16 samples are buffered. The 17th sample stalls until the first drain.
- **Handshake contract.** `in_rdy_o` depends only on registered state, so there is no combinational path from `out_rdy_i` to `in_rdy_o`. Upstream must hold its data while `in_vld_i && !in_rdy_o`.

## Structure
- `` `DATA_WID ``, and a new `` `FFT_PTS8 `` (=8), go in `fft_defines.vh`.
- Add a `bitrev3` function to `fft_defines.vh`, shared with the output reorder stage.
- One sub-module is natural: `fft_pack_bank`. It is one 8-lane complex register bank with a write-enable and a lane select, instantiated twice.
- The top level holds the pointers, flags and output mux.

## Test plan
- **Bit-reversed ramp.** After reset, feed re=1..8 and im=-1..-8 back-to-back with `out_rdy_i=1` → one `out_vld_o` pulse the cycle after the 8th accept. Lanes 0..7 carry re 1,5,3,7,2,6,4,8 and im -1,-5,-3,-7,-2,-6,-4,-8.
- **Natural order.** Repeat the ramp with `BITREV=0` → lanes carry re 1..8 in order.
- **Backpressure.** Hold `out_rdy_i=0` and feed 20 samples → `in_rdy_o` falls after 16 accepts and `level_o=2`. The first vector stays stable. Raising `out_rdy_i` for one cycle drains vector A, and `in_rdy_o` rises the next cycle. Sample 17 appears in the third vector, lane 0.
- **Continuous stream.** Sustain the input for 64 samples with `out_rdy_i=1` → 8 vectors, `in_rdy_o` never low, and `level_o` never exceeds 1.
- **Flush mid-group.** Flush after 5 accepts, then feed 8 new samples (100..107) → the first output vector contains only 100..107, bit-reversed.
- **Reset mid-operation.** Assert `rst_n` low with one full bank plus 3 samples → `out_vld_o=0`, outputs 0, `in_rdy_o=1` and `level_o=0` immediately. The next 8 samples form a correct vector.
